// File: rtl/rat_pkg.sv
// Shared types and constants for the RAT flag / interrupt control stage.
package rat_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        REQ  = 2'd2
    } int_state_t;

    localparam logic FLG_SRC_ALU  = 1'b0;
    localparam logic FLG_SRC_SHAD = 1'b1;

endpackage

// File: rtl/rat_flags_intr_int_sync.sv
// Multi-flop synchroniser for the asynchronous interrupt line plus a
// rising-edge detector producing a single-cycle EDGE pulse.
module int_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic CLK,
    input  logic RST,
    input  logic ASYNC_IN,
    output logic EDGE
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   last_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync   <= '0;
            last_q <= 1'b0;
        end else begin
            sync   <= {sync[SYNC_STAGES-2:0], ASYNC_IN};
            last_q <= sync[SYNC_STAGES-1];
        end
    end

    assign EDGE = sync[SYNC_STAGES-1] & ~last_q;

endmodule

// File: rtl/rat_flags_intr.sv
// Architectural C/Z flags, interrupt shadow flags, interrupt-enable flag and
// the request FSM that aligns external interrupts to instruction boundaries.
module rat_flags_intr
    import rat_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic CLK,
    input  logic RST,
    input  logic C_IN,
    input  logic Z_IN,
    input  logic FLG_C_LD,
    input  logic FLG_Z_LD,
    input  logic FLG_LD_SEL,
    input  logic FLG_C_SET,
    input  logic FLG_C_CLR,
    input  logic I_SET,
    input  logic I_CLR,
    input  logic INT_IN,
    input  logic INSTR_DONE,
    input  logic INT_ACK,
    output logic C_FLAG,
    output logic Z_FLAG,
    output logic I_FLAG,
    output logic INT_REQ
);

    int_state_t state;
    logic       sc;
    logic       sz;
    logic       edge_pulse;
    logic       c_src;
    logic       z_src;

    int_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_int_sync (
        .CLK      (CLK),
        .RST      (RST),
        .ASYNC_IN (INT_IN),
        .EDGE     (edge_pulse)
    );

    assign c_src = (FLG_LD_SEL == FLG_SRC_SHAD) ? sc : C_IN;
    assign z_src = (FLG_LD_SEL == FLG_SRC_SHAD) ? sz : Z_IN;

    // Shadow captures the pre-update flags, so a restore in the ack cycle
    // still reads the old shadow values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            C_FLAG <= 1'b0;
            Z_FLAG <= 1'b0;
            I_FLAG <= 1'b0;
            sc     <= 1'b0;
            sz     <= 1'b0;
        end else begin
            if (FLG_C_CLR)      C_FLAG <= 1'b0;
            else if (FLG_C_SET) C_FLAG <= 1'b1;
            else if (FLG_C_LD)  C_FLAG <= c_src;

            if (FLG_Z_LD) Z_FLAG <= z_src;

            if (INT_ACK) begin
                sc <= C_FLAG;
                sz <= Z_FLAG;
            end

            if (INT_ACK || I_CLR) I_FLAG <= 1'b0;
            else if (I_SET)       I_FLAG <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            INT_REQ <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (edge_pulse) state <= PEND;
                end
                PEND: begin
                    if (I_FLAG && INSTR_DONE) begin
                        state   <= REQ;
                        INT_REQ <= 1'b1;
                    end
                end
                REQ: begin
                    if (INT_ACK) begin
                        state   <= edge_pulse ? PEND : IDLE;
                        INT_REQ <= 1'b0;
                    end else if (!I_FLAG) begin
                        state   <= PEND;
                        INT_REQ <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    INT_REQ <= 1'b0;
                end
            endcase
        end
    end

endmodule
